// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back burst block.
//   wb_state_t : FSM state encoding (IDLE, RUN, DONE)
//   sat_signed : sign-extend an acc_w-bit value held in 64 bits, then clamp
//                it to the signed range of data_w bits
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_t;

  // The argument is treated as an acc_w-bit two's-complement value. Any
  // bits above acc_w are discarded and replaced with copies of its sign bit.
  // The result is the clamped value, still held in 64 bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] in,
                                                    input int acc_w,
                                                    input int data_w);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = (in <<< (64 - acc_w)) >>> (64 - acc_w);
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/wb_lane_quant.sv
// Combinational post-processing for one accumulator lane.
// The lane is arithmetic-shifted right by SHIFT. If relu_en is set,
// negative results become 0. The value is then saturated to DATA_W bits.
// Ports:
//   acc     : ACC_W-bit signed accumulator value
//   relu_en : clamp negative shifted values to zero
//   q       : DATA_W-bit signed result
module wb_lane_quant
  import wb_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 8
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic              relu_en,
  output logic [DATA_W-1:0] q
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] gated;

  always_comb begin
    shifted = $signed(acc) >>> SHIFT;
    gated   = (relu_en && shifted[ACC_W-1]) ? '0 : shifted;
    // The size cast sign-extends because gated is signed.
    q       = DATA_W'(sat_signed(64'(gated), ACC_W, DATA_W));
  end

endmodule

// File: rtl/write_back_burst.sv
// Burst write-back from the accumulator drain port to the output SRAM.
// On write_start, the block latches a destination address, a word count
// and a ReLU flag. It then accepts that many vectors from the drain port.
// Each lane of each vector is quantised. Each quantised vector is written
// one cycle later, at consecutive addresses that wrap at 2^ADDR_W.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   write_start          : start request, only looked at in IDLE
//   addr_des, len        : first address and word count, latched on start
//   relu_en              : ReLU enable, latched on start
//   acc_valid, acc_ready : drain handshake
//   acc_data             : LANES x ACC_W input vector
//   mem_we, mem_addr     : registered SRAM write strobe and address
//   mem_wdata            : registered LANES x DATA_W write data
//   busy                 : high in RUN and DONE
//   write_done           : one-cycle pulse, coincident with the last write
//   dbg_state            : current FSM state code, for observation
//
// Handshake: a vector transfers on every rising edge where acc_valid and
// acc_ready are both high. acc_ready depends only on the state, never on
// acc_valid. The producer may raise or drop acc_valid in any cycle; a
// cycle with acc_valid low transfers nothing.
module write_back_burst
  import wb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LANES  = 4,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int SHIFT  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_start,
  input  logic [ADDR_W-1:0]       addr_des,
  input  logic [LEN_W-1:0]        len,
  input  logic                    relu_en,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic [LANES*ACC_W-1:0]  acc_data,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES*DATA_W-1:0] mem_wdata,
  output logic                    busy,
  output logic                    write_done,
  output logic [1:0]              dbg_state
);

  wb_state_t               state;
  wb_state_t               next_state;
  logic [ADDR_W-1:0]       addr_q;
  logic [LEN_W-1:0]        remaining;
  logic                    relu_q;
  logic                    beat;
  logic [LANES*DATA_W-1:0] quant;

  // The ReLU flag comes from the latched copy, so toggling relu_en
  // mid-burst cannot affect data that is already in flight.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    wb_lane_quant #(
      .ACC_W (ACC_W),
      .DATA_W(DATA_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .acc    (acc_data[i*ACC_W +: ACC_W]),
      .relu_en(relu_q),
      .q      (quant[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    acc_ready  = 1'b0;
    busy       = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: begin
        if (write_start) begin
          next_state = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_ready = 1'b1;
        busy      = 1'b1;
        if (acc_valid && (remaining == LEN_W'(1))) begin
          next_state = DONE;
        end
      end
      DONE: begin
        // The final beat registered its write on the edge that entered
        // DONE, so this pulse lines up with the last mem_we.
        busy       = 1'b1;
        write_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign beat      = acc_valid && acc_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remaining <= '0;
      relu_q    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= beat;
      if ((state == IDLE) && write_start) begin
        addr_q    <= addr_des;
        remaining <= len;
        relu_q    <= relu_en;
      end else if (beat) begin
        mem_addr  <= addr_q;
        mem_wdata <= quant;
        // Natural ADDR_W-bit rollover gives the 1023 -> 0 wrap.
        addr_q    <= addr_q + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_write_back_burst.sv
module tb_write_back_burst;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;
  localparam int WD_W   = 64;
  localparam int AD_W   = 128;
  localparam int SB_W   = ADDR_W + WD_W;

  logic              clk;
  logic              rst_n;
  logic              write_start;
  logic [ADDR_W-1:0] addr_des;
  logic [LEN_W-1:0]  len;
  logic              relu_en;
  logic              acc_valid;
  logic              acc_ready;
  logic [AD_W-1:0]   acc_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WD_W-1:0]   mem_wdata;
  logic              busy;
  logic              write_done;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SB_W-1:0] exp_q[$];

  typedef struct {
    logic [AD_W-1:0] acc;
    logic            relu;
    logic [WD_W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  write_back_burst dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_start(write_start),
    .addr_des   (addr_des),
    .len        (len),
    .relu_en    (relu_en),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .write_done (write_done),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Runs one burst. Entry and exit are just after a rising edge with the
  // DUT in IDLE. pat bit c gives acc_valid for RUN cycle c; bits beyond 31
  // count as 1. If poke >= 0, a spurious start is raised in that cycle.
  task automatic do_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n,
                          input logic r, input logic [AD_W-1:0] data,
                          input logic [WD_W-1:0] exp_word, input logic [31:0] pat,
                          input int poke);
    int beats;
    int c;
    logic exp_we;
    logic nb;
    logic done_seen;
    logic [ADDR_W-1:0] ea;
    logic [SB_W-1:0] e;
    beats = 0;
    c = 0;
    exp_we = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      ea = a + ADDR_W'(i);
      exp_q.push_back({ea, exp_word});
    end
    write_start = 1'b1;
    addr_des = a;
    len = n;
    relu_en = r;
    acc_valid = 1'b0;
    acc_data = data;
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_done", 128'(write_done), 128'(0));
    check("idle_ready", 128'(acc_ready), 128'(0));
    @(posedge clk); #1;
    write_start = 1'b0;
    addr_des = ~a;
    len = ~n;
    relu_en = ~r;
    while (!done_seen && c < 200) begin
      acc_valid = (c < 32) ? pat[c] : 1'b1;
      acc_data = data;
      if (c == poke) begin
        write_start = 1'b1;
        addr_des = 10'h200;
        len = 8'd7;
      end else begin
        write_start = 1'b0;
      end
      nb = acc_valid && (beats < int'(n));
      @(negedge clk);
      if (c == 0) check("run_ready", 128'(acc_ready), 128'(n != 0));
      check("mem_we", 128'(mem_we), 128'(exp_we));
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_write: got write at 0x%0h, expected none", mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 128'(mem_addr), 128'(e[SB_W-1:WD_W]));
          check("wr_data", 128'(mem_wdata), 128'(e[WD_W-1:0]));
        end
      end
      if (write_done) begin
        done_seen = 1'b1;
        check("done_beats", 128'(beats), 128'(n));
        check("done_with_last_we", 128'(mem_we), 128'(n != 0));
        check("sb_empty", 128'(exp_q.size()), 128'(0));
      end
      exp_we = nb;
      if (nb) beats++;
      @(posedge clk); #1;
      c++;
    end
    acc_valid = 1'b0;
    write_start = 1'b0;
    if (!done_seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no write_done, expected one within 200 cycles");
      exp_q.delete();
    end
  endtask

  task automatic reset_mid_burst();
    write_start = 1'b1;
    addr_des = 10'h300;
    len = 8'd5;
    relu_en = 1'b0;
    acc_valid = 1'b0;
    acc_data = {4{32'h0000_0200}};
    @(posedge clk); #1;
    write_start = 1'b0;
    acc_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_we", 128'(mem_we), 128'(1));
    check("pre_rst_addr", 128'(mem_addr), 128'(10'h301));
    #2 rst_n = 1'b0;
    #1;
    check("rst_we", 128'(mem_we), 128'(0));
    check("rst_addr", 128'(mem_addr), 128'(0));
    check("rst_wdata", 128'(mem_wdata), 128'(0));
    check("rst_ready", 128'(acc_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(write_done), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_we", 128'(mem_we), 128'(0));
      check("rst_hold_done", 128'(write_done), 128'(0));
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_we", 128'(mem_we), 128'(0));
      check("post_rst_done", 128'(write_done), 128'(0));
      check("post_rst_busy", 128'(busy), 128'(0));
    end
    acc_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{acc: {4{32'h0000_0100}}, relu: 1'b1, exp: {4{16'h0001}}};
    vecs[1] = '{acc: {32'h0000_0000, 32'hFFFF_FF00, 32'h8001_0000, 32'h7FFF_0000},
                relu: 1'b0, exp: {16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF}};
    vecs[2] = '{acc: {32'h0000_0000, 32'hFFFF_FF00, 32'h8001_0000, 32'h7FFF_0000},
                relu: 1'b1, exp: {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}};
    vecs[3] = '{acc: {32'hFF7F_FF00, 32'h0080_0000, 32'hFFFF_FFFF, 32'h0001_2345},
                relu: 1'b0, exp: {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0123}};
    vecs[4] = '{acc: {32'h8000_0000, 32'h0000_00FF, 32'hFF80_0000, 32'h007F_FF00},
                relu: 1'b0, exp: {16'h8000, 16'h0000, 16'h8000, 16'h7FFF}};
    vecs[5] = '{acc: {32'h8000_0000, 32'h0000_00FF, 32'hFF80_0000, 32'h007F_FF00},
                relu: 1'b1, exp: {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}};

    rst_n = 1'b0;
    write_start = 1'b0;
    addr_des = '0;
    len = '0;
    relu_en = 1'b0;
    acc_valid = 1'b0;
    acc_data = '0;
    #2;
    check("reset_we", 128'(mem_we), 128'(0));
    check("reset_addr", 128'(mem_addr), 128'(0));
    check("reset_wdata", 128'(mem_wdata), 128'(0));
    check("reset_ready", 128'(acc_ready), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(write_done), 128'(0));
    check("reset_state", 128'(dbg_state), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst, valid held high
    do_burst(10'h010, 8'd4, 1'b0, {4{32'h0000_0100}}, {4{16'h0001}}, '1, -1);
    // Backpressure pattern 1,0,0,1,0,1
    do_burst(10'h020, 8'd3, 1'b0,
             {32'h0000_0000, 32'hFFFF_F000, 32'h0000_0800, 32'h0000_1000},
             {16'h0000, 16'hFFF0, 16'h0008, 16'h0010}, 32'b101001, -1);
    // Lane processing table
    for (int i = 0; i < 6; i++) begin
      do_burst(10'h040 + ADDR_W'(4 * i), 8'd2, vecs[i].relu, vecs[i].acc, vecs[i].exp, '1, -1);
    end
    // Address wrap, then zero length back-to-back
    do_burst(10'd1022, 8'd3, 1'b1,
             {32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0500, 32'hFFFF_0000},
             {16'h0000, 16'h7FFF, 16'h0005, 16'h0000}, '1, -1);
    do_burst(10'h155, 8'd0, 1'b0, '0, '0, '1, -1);
    // Start while busy is ignored
    do_burst(10'h080, 8'd4, 1'b0,
             {32'h0000_FF00, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000},
             {16'h00FF, 16'h0100, 16'h0200, 16'h0300}, '1, 1);
    // The idle check at the start of this burst confirms a single done pulse
    do_burst(10'h0A0, 8'd1, 1'b0, {4{32'h0000_0300}}, {4{16'h0003}}, '1, -1);
    // Reset mid-burst, then a clean burst
    reset_mid_burst();
    do_burst(10'h3F0, 8'd2, 1'b0, {4{32'h0000_0A00}}, {4{16'h000A}}, 32'b110, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/write_back_burst.md
# write_back_burst

Parametrised successor to the single-cycle write-back handshake. It accepts a burst of `len` accumulator vectors from the systolic array drain port and post-processes each lane. Post-processing is an arithmetic shift, optional ReLU, then saturation to `DATA_W`. Each processed vector is written to the output buffer starting at `addr_des`, and `write_done` pulses when the last word lands. The block sits between the accumulator drain and the output SRAM write port, and the top-level controller drives it.

## Interface
- `DATA_W`, 16, output element width (signed)
- `ACC_W`, 32, accumulator element width (signed)
- `LANES`, 4, elements per vector / SRAM word
- `ADDR_W`, 10, output buffer address width
- `LEN_W`, 8, burst length width
- `SHIFT`, 8, arithmetic right-shift applied before saturation (0..ACC_W-1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `write_start` in 1: start request, sampled in IDLE only
- `addr_des` in `ADDR_W`: first destination address, latched on start
- `len` in `LEN_W`: number of words in burst, latched on start
- `relu_en` in 1: clamp negatives to 0, latched on start
- `acc_valid` in 1: drain data valid
- `acc_ready` out 1: block can accept a vector
- `acc_data` in `LANES*ACC_W`: lane i at `[i*ACC_W +: ACC_W]`
- `mem_we` out 1: SRAM write enable
- `mem_addr` out `ADDR_W`: SRAM address
- `mem_wdata` out `LANES*DATA_W`: lane i at `[i*DATA_W +: DATA_W]`
- `busy` out 1: high in RUN and DONE
- `write_done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `acc_ready`=0.
  - On `write_start`, latch `addr_des`, `len`, `relu_en`. Go to DONE if `len`==0, else go to RUN.
- RUN:
  - `acc_ready`=1.
  - Beat = `acc_valid`&&`acc_ready`. Each beat registers the processed vector, current address and `mem_we`=1 for the next cycle.
  - Address increments by 1 and wraps modulo 2^`ADDR_W` (1023→0), with no error.
  - Remaining count decrements. The beat taking it to 0 moves the FSM to DONE.
  - Cycles without `acc_valid` insert no write (`mem_we`=0).
- DONE:
  - `write_done`=1 for exactly one cycle, then return to IDLE.
  - For nonzero `len`, this is the same cycle in which the last `mem_we` is high.
- Lane processing:
  - s = `acc` >>> `SHIFT` (sign-preserving).
  - If `relu_en` and s<0, s=0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- `write_start` during RUN/DONE is ignored; it is not queued.
- `len`==0: one DONE cycle with `write_done`=1 and no `mem_we`.
- Inputs changing after start have no effect on the in-flight burst.

## Timing
- Reset values: state IDLE. `acc_ready`, `mem_we`, `busy`, `write_done` = 0. `mem_addr`, `mem_wdata` = 0.
- Reset mid-burst aborts immediately: no further writes, no `write_done`.
- Start sampled at edge t: state RUN from t; `acc_ready` high in cycle t+1.
- Write latency: beat at edge k gives `mem_we`/`mem_addr`/`mem_wdata` valid in cycle k+1 (one register stage).
- With `acc_valid` held high, an N-word burst yields N consecutive write cycles. `write_done` is high in the Nth write cycle, and `busy` falls the cycle after.
- Back-to-back bursts: next `write_start` is accepted in the first IDLE cycle after DONE.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.

## Structure
- Package `wb_pkg`:
  - state enum `wb_state_t` {IDLE, RUN, DONE}
  - saturation function `sat_signed(in, ACC_W, DATA_W)`
- Sub-module `wb_lane_quant`:
  - combinational shift/ReLU/saturate for one lane, parameters `ACC_W`, `DATA_W`, `SHIFT`
  - instantiated `LANES` times via generate
- Top holds the FSM, address counter, remaining-count counter and the output register stage.

## Test plan
- Basic burst: start with `addr_des`=0x010, `len`=4, `acc_valid` held high, lane data 0x100, `SHIFT`=8 → writes at 0x010..0x013, each lane=0x0001. `write_done` is high with the 4th `mem_we`.
- Backpressure gaps: `len`=3, `acc_valid` pattern 1,0,0,1,0,1 → exactly 3 writes, no `mem_we` in gap cycles, addresses consecutive.
- Saturation/ReLU: lane values 0x7FFF_0000, -0x7FFF_0000, -256 with `relu_en`=0 → 0x7FFF, 0x8000, 0xFFFF. Repeat with `relu_en`=1 → 0x7FFF, 0x0000, 0x0000.
- Wrap and zero length: `addr_des`=1022, `len`=3 → addresses 1022, 1023, 0. Then `len`=0 → `write_done` pulse one cycle after start, no `mem_we`.
- Start while busy: second `write_start` with `addr_des`=0x200 during RUN → ignored, original burst completes unaltered, single `write_done`.
- Reset mid-burst: `rst_n` low after 2 of 5 beats → all outputs 0 asynchronously, no `write_done`. A new start after release runs a clean burst.
